// File: rtl/ps2_keyb_if.sv
// PS/2 keyboard and ULA matrix signal bundle.
// Master drives the keyboard lines and row selects; slave answers columns.
interface ps2_keyb_if;
  logic       ps2clk;
  logic       ps2data;
  logic [7:0] kbrows;
  logic [4:0] kbcolumns;
  logic       kbd_err;

  modport master (
    output ps2clk, ps2data, kbrows,
    input  kbcolumns, kbd_err
  );

  modport slave (
    input  ps2clk, ps2data, kbrows,
    output kbcolumns, kbd_err
  );
endinterface

// File: rtl/ps2_keyb_matrix.sv
// PS/2 set-2 receiver feeding the 8x5 Spectrum key matrix.
// Answers ULA half-row scans with registered active-low columns.
module ps2_keyb_matrix #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 14000
) (
  input  logic clk14,
  input  logic rst_n,
  ps2_keyb_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} st_t;

  st_t         state_q, state_d;
  logic [1:0]  ck_q, ck_d, dt_q, dt_d;
  logic        filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic        bad_q, bad_d;
  logic        err_q, err_d;
  logic        vld_q, vld_d;
  logic        brk_q, brk_d;
  logic        ext_q, ext_d;
  logic [42:0] key_q, key_d;
  logic [4:0]  cols_q, cols_d;
  logic        fall, chg, din, tmo_hit;
  logic [5:0]  idx;
  logic [39:0] mtx;
  logic [7:0]  sel;

  // Indices 0..39 are row*5+col; 40/41 are the shifts, 42 is backspace.
  function automatic logic [5:0] key_idx(input logic [7:0] c);
    case (c)
      8'h1A: key_idx = 6'd1;  8'h22: key_idx = 6'd2;
      8'h21: key_idx = 6'd3;  8'h2A: key_idx = 6'd4;
      8'h1C: key_idx = 6'd5;  8'h1B: key_idx = 6'd6;
      8'h23: key_idx = 6'd7;  8'h2B: key_idx = 6'd8;
      8'h34: key_idx = 6'd9;  8'h15: key_idx = 6'd10;
      8'h1D: key_idx = 6'd11; 8'h24: key_idx = 6'd12;
      8'h2D: key_idx = 6'd13; 8'h2C: key_idx = 6'd14;
      8'h16: key_idx = 6'd15; 8'h1E: key_idx = 6'd16;
      8'h26: key_idx = 6'd17; 8'h25: key_idx = 6'd18;
      8'h2E: key_idx = 6'd19; 8'h45: key_idx = 6'd20;
      8'h46: key_idx = 6'd21; 8'h3E: key_idx = 6'd22;
      8'h3D: key_idx = 6'd23; 8'h36: key_idx = 6'd24;
      8'h4D: key_idx = 6'd25; 8'h44: key_idx = 6'd26;
      8'h43: key_idx = 6'd27; 8'h3C: key_idx = 6'd28;
      8'h35: key_idx = 6'd29; 8'h5A: key_idx = 6'd30;
      8'h4B: key_idx = 6'd31; 8'h42: key_idx = 6'd32;
      8'h3B: key_idx = 6'd33; 8'h33: key_idx = 6'd34;
      8'h29: key_idx = 6'd35; 8'h14: key_idx = 6'd36;
      8'h3A: key_idx = 6'd37; 8'h31: key_idx = 6'd38;
      8'h32: key_idx = 6'd39; 8'h12: key_idx = 6'd40;
      8'h59: key_idx = 6'd41; 8'h66: key_idx = 6'd42;
      default: key_idx = 6'd63;
    endcase
  endfunction

  assign din = dt_q[1];

  always_comb begin
    ck_d   = {ck_q[0], bus.ps2clk};
    dt_d   = {dt_q[0], bus.ps2data};
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (ck_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = ck_q[1];
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    chg = (filt_d != filt_q);
  end

  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (state_q != IDLE && !chg) begin
      tmo_d   = tmo_q + 1'b1;
      tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk14) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!din) state_d = DATA;
        DATA:    if (bcnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sh_d   = sh_q;
    bcnt_d = bcnt_q;
    bad_d  = bad_q;
    err_d  = 1'b0;
    vld_d  = 1'b0;
    if (tmo_hit) begin
      err_d = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          bcnt_d = '0;
          bad_d  = 1'b0;
        end
        DATA: begin
          sh_d   = {din, sh_q[7:1]};
          bcnt_d = bcnt_q + 1'b1;
        end
        PARITY:  bad_d = ~(^{sh_q, din});
        default: begin
          vld_d = din & ~bad_q;
          err_d = ~din | bad_q;
        end
      endcase
    end
  end

  always_comb begin
    key_d = key_q;
    brk_d = brk_q;
    ext_d = ext_q;
    idx   = key_idx(sh_q);
    if (vld_q) begin
      if (sh_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (sh_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        if (!ext_q && idx != 6'd63) key_d[idx] = ~brk_q;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_comb begin
    mtx     = key_q[39:0];
    mtx[0]  = key_q[0] | key_q[40] | key_q[41] | key_q[42];
    mtx[20] = key_q[20] | key_q[42];
    sel = ~{bus.kbrows[0], bus.kbrows[1], bus.kbrows[3],
            bus.kbrows[4], bus.kbrows[7], bus.kbrows[6],
            bus.kbrows[5], bus.kbrows[2]};
    cols_d = 5'b11111;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (sel[r] && mtx[r*5+c]) cols_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk14) begin
    if (!rst_n) begin
      ck_q   <= 2'b11;
      dt_q   <= 2'b11;
      filt_q <= 1'b1;
      fcnt_q <= '0;
      tmo_q  <= '0;
      sh_q   <= '0;
      bcnt_q <= '0;
      bad_q  <= 1'b0;
      err_q  <= 1'b0;
      vld_q  <= 1'b0;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      key_q  <= '0;
      cols_q <= 5'b11111;
    end else begin
      ck_q   <= ck_d;
      dt_q   <= dt_d;
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      tmo_q  <= tmo_d;
      sh_q   <= sh_d;
      bcnt_q <= bcnt_d;
      bad_q  <= bad_d;
      err_q  <= err_d;
      vld_q  <= vld_d;
      brk_q  <= brk_d;
      ext_q  <= ext_d;
      key_q  <= key_d;
      cols_q <= cols_d;
    end
  end

  assign bus.kbcolumns = cols_q;
  assign bus.kbd_err   = err_q;
endmodule

// File: tb/tb_ps2_keyb_matrix.sv
// Bench for ps2_keyb_matrix: vector table, corner sequences and
// randomised keystrokes against a per-scancode key model.
module tb_ps2_keyb_matrix;
  localparam int H   = 14;
  localparam int TMO = 1000;

  logic clk14 = 1'b0;
  logic rst_n = 1'b0;
  ps2_keyb_if bus ();

  ps2_keyb_matrix #(.FILTER_LEN(8), .TIMEOUT(TMO)) dut (
    .clk14(clk14),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk14 = ~clk14;

  int checks = 0;
  int failures = 0;
  int errs = 0;

  always @(negedge clk14) if (bus.kbd_err === 1'b1) errs++;

  typedef struct {
    logic [7:0] code;
    logic       brk;
    logic [7:0] rows;
    logic [4:0] exp;
  } vec_t;

  bit down [256];
  bit mbrk, mext;

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) down[i] = 1'b0;
    mbrk = 1'b0;
    mext = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] c);
    if (c == 8'hF0) mbrk = 1'b1;
    else if (c == 8'hE0) mext = 1'b1;
    else begin
      if (!mext) down[c] = ~mbrk;
      mbrk = 1'b0;
      mext = 1'b0;
    end
  endfunction

  // Matrix position row*5+col (row 0 = A8) of a key; k picks a second spot.
  function automatic int pos(input logic [7:0] c, input int k);
    int p;
    p = -1;
    if (k == 1) return (c == 8'h66) ? 20 : -1;
    case (c)
      8'h12, 8'h59, 8'h66: p = 0;
      8'h1A: p = 1;  8'h22: p = 2;  8'h21: p = 3;  8'h2A: p = 4;
      8'h1C: p = 5;  8'h1B: p = 6;  8'h23: p = 7;  8'h2B: p = 8;
      8'h34: p = 9;  8'h15: p = 10; 8'h1D: p = 11; 8'h24: p = 12;
      8'h2D: p = 13; 8'h2C: p = 14; 8'h16: p = 15; 8'h1E: p = 16;
      8'h26: p = 17; 8'h25: p = 18; 8'h2E: p = 19; 8'h45: p = 20;
      8'h46: p = 21; 8'h3E: p = 22; 8'h3D: p = 23; 8'h36: p = 24;
      8'h4D: p = 25; 8'h44: p = 26; 8'h43: p = 27; 8'h3C: p = 28;
      8'h35: p = 29; 8'h5A: p = 30; 8'h4B: p = 31; 8'h42: p = 32;
      8'h3B: p = 33; 8'h33: p = 34; 8'h29: p = 35; 8'h14: p = 36;
      8'h3A: p = 37; 8'h31: p = 38; 8'h32: p = 39;
      default: p = -1;
    endcase
    return p;
  endfunction

  function automatic logic [4:0] exp_cols(input logic [7:0] rows);
    int l2b [8];
    logic [4:0] r;
    int p;
    l2b = '{2, 5, 6, 7, 4, 3, 1, 0};
    r = 5'b11111;
    for (int c = 0; c < 256; c++) begin
      if (down[c]) begin
        for (int k = 0; k < 2; k++) begin
          p = pos(8'(c), k);
          if (p >= 0 && rows[l2b[p/5]] == 1'b0) r[p%5] = 1'b0;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk14);
    bus.ps2data = b;
    repeat (H) @(negedge clk14);
    bus.ps2clk = 1'b0;
    repeat (H) @(negedge clk14);
    bus.ps2clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] c, input logic par_ok,
                          input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit((~^c) ^ ~par_ok);
    ps2_bit(stop);
    bus.ps2data = 1'b1;
    repeat (2*H) @(negedge clk14);
  endtask

  task automatic send(input logic [7:0] c);
    send_raw(c, 1'b1, 1'b1);
    model_byte(c);
  endtask

  task automatic cols_chk(input string name, input logic [7:0] rows,
                          input logic [4:0] exp);
    bus.kbrows = rows;
    repeat (4) @(negedge clk14);
    chk(name, 32'(bus.kbcolumns), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk14);
    rst_n = 1'b0;
    repeat (5) @(negedge clk14);
    rst_n = 1'b1;
    model_clear();
  endtask

  vec_t tbl [24];
  logic [7:0] codes [48];
  int e0;
  logic [7:0] c, rows;

  initial begin
    bus.ps2clk  = 1'b1;
    bus.ps2data = 1'b1;
    bus.kbrows  = 8'h00;
    model_clear();
    repeat (5) @(negedge clk14);
    chk("reset_cols", 32'(bus.kbcolumns), 32'h1F);
    chk("reset_err", 32'(bus.kbd_err), 32'h0);
    rst_n = 1'b1;

    tbl[0]  = '{8'h1C, 1'b0, 8'hDF, 5'b11110};
    tbl[1]  = '{8'h1C, 1'b1, 8'hDF, 5'b11111};
    tbl[2]  = '{8'h15, 1'b0, 8'hBF, 5'b11110};
    tbl[3]  = '{8'h29, 1'b0, 8'h00, 5'b11110};
    tbl[4]  = '{8'h3A, 1'b0, 8'hFE, 5'b11010};
    tbl[5]  = '{8'h14, 1'b0, 8'hFE, 5'b11000};
    tbl[6]  = '{8'h15, 1'b1, 8'hBF, 5'b11111};
    tbl[7]  = '{8'h29, 1'b1, 8'hFE, 5'b11001};
    tbl[8]  = '{8'h45, 1'b0, 8'hEF, 5'b11110};
    tbl[9]  = '{8'h46, 1'b0, 8'hEF, 5'b11100};
    tbl[10] = '{8'h16, 1'b0, 8'h7F, 5'b11110};
    tbl[11] = '{8'h35, 1'b0, 8'hF7, 5'b01111};
    tbl[12] = '{8'h33, 1'b0, 8'hFD, 5'b01111};
    tbl[13] = '{8'h5A, 1'b0, 8'hFD, 5'b01110};
    tbl[14] = '{8'h2A, 1'b0, 8'hFB, 5'b01111};
    tbl[15] = '{8'h1C, 1'b0, 8'hDF, 5'b11110};
    tbl[16] = '{8'h1C, 1'b0, 8'hDF, 5'b11110};
    tbl[17] = '{8'h1B, 1'b1, 8'hDF, 5'b11110};
    tbl[18] = '{8'h12, 1'b0, 8'hFB, 5'b01110};
    tbl[19] = '{8'h59, 1'b0, 8'hFB, 5'b01110};
    tbl[20] = '{8'h12, 1'b1, 8'hFB, 5'b01110};
    tbl[21] = '{8'h59, 1'b1, 8'hFB, 5'b01111};
    tbl[22] = '{8'hAA, 1'b0, 8'hFB, 5'b01111};
    tbl[23] = '{8'h1C, 1'b0, 8'hFF, 5'b11111};

    for (int i = 0; i < 24; i++) begin
      if (tbl[i].brk) send(8'hF0);
      send(tbl[i].code);
      cols_chk($sformatf("vec%0d", i), tbl[i].rows, tbl[i].exp);
    end
    chk("vec_no_err", errs, 0);

    do_reset();
    e0 = errs;
    send_raw(8'h1C, 1'b0, 1'b1);
    chk("parity_err", errs - e0, 1);
    cols_chk("parity_nochg", 8'hDF, 5'b11111);
    e0 = errs;
    send_raw(8'h1C, 1'b1, 1'b0);
    chk("stop_err", errs - e0, 1);
    cols_chk("stop_nochg", 8'hDF, 5'b11111);

    e0 = errs;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 100) @(negedge clk14);
    chk("timeout_err", errs - e0, 1);
    e0 = errs;
    send(8'h1A);
    cols_chk("after_timeout_z", 8'hFB, 5'b11101);
    chk("after_timeout_noerr", errs - e0, 0);

    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    cols_chk("ext_nochg", 8'h00, 5'b11101);
    send(8'h1C);
    cols_chk("ext_flags_clear", 8'h00, 5'b11100);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h1A);
    cols_chk("all_released", 8'h00, 5'b11111);

    send(8'h12); send(8'h66);
    send(8'hF0); send(8'h12);
    cols_chk("bksp_caps", 8'hFB, 5'b11110);
    cols_chk("bksp_zero", 8'hEF, 5'b11110);
    send(8'hF0); send(8'h66);
    cols_chk("bksp_release", 8'h00, 5'b11111);

    e0 = errs;
    @(negedge clk14);
    bus.ps2data = 1'b0;
    bus.ps2clk  = 1'b0;
    repeat (7) @(negedge clk14);
    bus.ps2clk  = 1'b1;
    bus.ps2data = 1'b1;
    repeat (50) @(negedge clk14);
    send(8'h1C);
    cols_chk("glitch_frame_ok", 8'hDF, 5'b11110);
    repeat (TMO + 100) @(negedge clk14);
    chk("glitch_noerr", errs - e0, 0);

    codes = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h1C, 8'h1B, 8'h23, 8'h2B,
              8'h34, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h16, 8'h1E,
              8'h26, 8'h25, 8'h2E, 8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
              8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35, 8'h5A, 8'h4B, 8'h42,
              8'h3B, 8'h33, 8'h29, 8'h14, 8'h3A, 8'h31, 8'h32, 8'h12,
              8'h59, 8'h66, 8'h75, 8'hAA, 8'hFA, 8'h0D, 8'h11, 8'h1C};
    e0 = errs;
    for (int i = 0; i < 30; i++) begin
      c = codes[$urandom_range(0, 47)];
      if ($urandom_range(0, 7) == 0) send(8'hE0);
      if ($urandom_range(0, 2) == 0) send(8'hF0);
      send(c);
      rows = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        rows = ~(8'h01 << $urandom_range(0, 7));
      cols_chk($sformatf("rand%0d", i), rows, exp_cols(rows));
    end
    chk("rand_noerr", errs - e0, 0);

    e0 = errs;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk14);
    rst_n = 1'b0;
    bus.kbrows = 8'h00;
    repeat (4) @(negedge clk14);
    chk("midreset_cols", 32'(bus.kbcolumns), 32'h1F);
    rst_n = 1'b1;
    model_clear();
    repeat (TMO + 100) @(negedge clk14);
    chk("midreset_noerr", errs - e0, 0);
    cols_chk("midreset_cleared", 8'h00, 5'b11111);
    send(8'h1C);
    cols_chk("midreset_recover", 8'hDF, 5'b11110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
